// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite round-robin master arbiter.
// Holds the AXI response encoding and the transaction FSM states.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i,
// wrapping modulo N. Output is one-hot, or all zero when nothing requests.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && i >= int'(ptr_i)) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        // Wrap-around pass picks the lowest index below the pointer
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4lite_rr_master_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ requesters, round-robin,
// one single-beat transaction outstanding at a time.
module axi4lite_rr_master_arbiter
    import axi4lite_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       A_CLK,
    input  logic                       A_RST,
    input  logic [N_REQ-1:0]           REQ_VALID,
    input  logic [N_REQ-1:0]           REQ_WRITE,
    input  logic [N_REQ*ADDR_W-1:0]    REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]    REQ_WDATA,
    input  logic [N_REQ*DATA_W/8-1:0]  REQ_WSTRB,
    output logic [N_REQ-1:0]           REQ_ACK,
    output logic [DATA_W-1:0]          RSP_RDATA,
    output logic [1:0]                 RSP_RESP,
    output logic                       AW_VALID,
    input  logic                       AW_READY,
    output logic [ADDR_W-1:0]          AW_ADDR,
    output logic                       W_VALID,
    input  logic                       W_READY,
    output logic [DATA_W-1:0]          W_DATA,
    output logic [DATA_W/8-1:0]        W_STRB,
    input  logic                       B_VALID,
    output logic                       B_READY,
    input  logic [1:0]                 B_RESP,
    output logic                       AR_VALID,
    input  logic                       AR_READY,
    output logic [ADDR_W-1:0]          AR_ADDR,
    input  logic                       R_VALID,
    output logic                       R_READY,
    input  logic [DATA_W-1:0]          R_DATA,
    input  logic [1:0]                 R_RESP
);

    localparam int PW = $clog2(N_REQ);
    localparam int SW = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [PW-1:0]       ptr_q;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    gnt_q;
    logic [PW-1:0]       gidx;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SW-1:0]       wstrb_q;
    logic                aw_valid_q;
    logic                w_valid_q;
    logic                ar_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    resp_t               resp_q;
    logic                grant;
    logic                aw_ok;
    logic                w_ok;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req_i (REQ_VALID),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
    end

    assign grant = (state_q == IDLE) && (|REQ_VALID);
    // A channel is finished once its VALID has dropped or is handshaking now
    assign aw_ok = !aw_valid_q || AW_READY;
    assign w_ok  = !w_valid_q || W_READY;

    always_ff @(posedge A_CLK) begin
        if (A_RST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|REQ_VALID) state_d = REQ_WRITE[gidx] ? WR : RD_ADDR;
            WR:      if (aw_ok && w_ok) state_d = WR_RESP;
            WR_RESP: if (B_VALID) state_d = DONE;
            RD_ADDR: if (AR_READY) state_d = RD_DATA;
            RD_DATA: if (R_VALID) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        REQ_ACK   = (state_q == DONE) ? gnt_q : '0;
        B_READY   = (state_q == WR_RESP);
        R_READY   = (state_q == RD_DATA);
        AW_VALID  = aw_valid_q;
        W_VALID   = w_valid_q;
        AR_VALID  = ar_valid_q;
        AW_ADDR   = addr_q;
        AR_ADDR   = addr_q;
        W_DATA    = wdata_q;
        W_STRB    = wstrb_q;
        RSP_RDATA = rdata_q;
        RSP_RESP  = resp_q;
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= OKAY;
        end else begin
            if (grant) begin
                gnt_q      <= gnt;
                ptr_q      <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                addr_q     <= REQ_ADDR[int'(gidx)*ADDR_W +: ADDR_W];
                wdata_q    <= REQ_WDATA[int'(gidx)*DATA_W +: DATA_W];
                wstrb_q    <= REQ_WSTRB[int'(gidx)*SW +: SW];
                aw_valid_q <= REQ_WRITE[gidx];
                w_valid_q  <= REQ_WRITE[gidx];
                ar_valid_q <= !REQ_WRITE[gidx];
            end
            if (aw_valid_q && AW_READY) aw_valid_q <= 1'b0;
            if (w_valid_q && W_READY)   w_valid_q  <= 1'b0;
            if (ar_valid_q && AR_READY) ar_valid_q <= 1'b0;
            if (state_q == WR_RESP && B_VALID) resp_q <= resp_t'(B_RESP);
            if (state_q == RD_DATA && R_VALID) begin
                rdata_q <= R_DATA;
                resp_q  <= resp_t'(R_RESP);
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_rr_master_arbiter.sv
// Directed bench for axi4lite_rr_master_arbiter with a delay-configurable
// AXI4-Lite slave model and hand-computed expected values.
module tb_axi4lite_rr_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              A_CLK;
    logic              A_RST;
    logic [N-1:0]      REQ_VALID;
    logic [N-1:0]      REQ_WRITE;
    logic [N*AW-1:0]   REQ_ADDR;
    logic [N*DW-1:0]   REQ_WDATA;
    logic [N*SW-1:0]   REQ_WSTRB;
    logic [N-1:0]      REQ_ACK;
    logic [DW-1:0]     RSP_RDATA;
    logic [1:0]        RSP_RESP;
    logic              AW_VALID, AW_READY;
    logic [AW-1:0]     AW_ADDR;
    logic              W_VALID, W_READY;
    logic [DW-1:0]     W_DATA;
    logic [SW-1:0]     W_STRB;
    logic              B_VALID, B_READY;
    logic [1:0]        B_RESP;
    logic              AR_VALID, AR_READY;
    logic [AW-1:0]     AR_ADDR;
    logic              R_VALID, R_READY;
    logic [DW-1:0]     R_DATA;
    logic [1:0]        R_RESP;

    axi4lite_rr_master_arbiter #(
        .N_REQ (N),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .A_CLK    (A_CLK),
        .A_RST    (A_RST),
        .REQ_VALID(REQ_VALID),
        .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .REQ_WSTRB(REQ_WSTRB),
        .REQ_ACK  (REQ_ACK),
        .RSP_RDATA(RSP_RDATA),
        .RSP_RESP (RSP_RESP),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .AW_ADDR  (AW_ADDR),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .W_DATA   (W_DATA),
        .W_STRB   (W_STRB),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_RESP   (B_RESP),
        .AR_VALID (AR_VALID),
        .AR_READY (AR_READY),
        .AR_ADDR  (AR_ADDR),
        .R_VALID  (R_VALID),
        .R_READY  (R_READY),
        .R_DATA   (R_DATA),
        .R_RESP   (R_RESP)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [DW-1:0] rdata_cfg = '0;
    logic [1:0]    bresp_cfg = 2'b00;
    logic [1:0]    rresp_cfg = 2'b00;
    int awc, wc, arc, bc, rc;

    int aw_hs_c = 0, w_hs_c = 0, ar_hs_c = 0, r_hs_c = 0;
    int stab_err = 0, bready_err = 0;
    logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [AW-1:0] p_awa = '0, p_ara = '0;
    logic [DW-1:0] p_wd = '0;
    logic [SW-1:0] p_ws = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave model: READY after a programmed wait, responses after READY
    initial begin
        AW_READY = 0; W_READY = 0; AR_READY = 0;
        B_VALID = 0; B_RESP = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
        forever begin
            @(posedge A_CLK);
            #2;
            if (A_RST) begin
                AW_READY = 0; W_READY = 0; AR_READY = 0;
                B_VALID = 0; R_VALID = 0;
                awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
            end else begin
                if (AW_VALID) begin
                    AW_READY = (awc >= aw_dly);
                    if (!AW_READY) awc++;
                end else begin
                    AW_READY = 0; awc = 0;
                end
                if (W_VALID) begin
                    W_READY = (wc >= w_dly);
                    if (!W_READY) wc++;
                end else begin
                    W_READY = 0; wc = 0;
                end
                if (AR_VALID) begin
                    AR_READY = (arc >= ar_dly);
                    if (!AR_READY) arc++;
                end else begin
                    AR_READY = 0; arc = 0;
                end
                if (B_READY) begin
                    B_VALID = (bc >= b_dly);
                    B_RESP  = bresp_cfg;
                    if (!B_VALID) bc++;
                end else begin
                    B_VALID = 0; bc = 0;
                end
                if (R_READY) begin
                    R_VALID = (rc >= r_dly);
                    R_DATA  = rdata_cfg;
                    R_RESP  = rresp_cfg;
                    if (!R_VALID) rc++;
                end else begin
                    R_VALID = 0; rc = 0;
                end
            end
        end
    end

    // Protocol monitor: handshake timestamps and VALID/payload stability
    always @(negedge A_CLK) begin
        cyc++;
        if (!A_RST) begin
            if (p_awv && !p_awr && (!AW_VALID || AW_ADDR !== p_awa)) stab_err++;
            if (p_wv && !p_wr && (!W_VALID || W_DATA !== p_wd || W_STRB !== p_ws))
                stab_err++;
            if (p_arv && !p_arr && (!AR_VALID || AR_ADDR !== p_ara)) stab_err++;
            if (B_READY && (AW_VALID || W_VALID)) bready_err++;
        end
        if (AW_VALID && AW_READY) aw_hs_c = cyc;
        if (W_VALID && W_READY)   w_hs_c  = cyc;
        if (AR_VALID && AR_READY) ar_hs_c = cyc;
        if (R_VALID && R_READY)   r_hs_c  = cyc;
        p_awv = AW_VALID; p_awr = AW_READY; p_awa = AW_ADDR;
        p_wv  = W_VALID;  p_wr  = W_READY;  p_wd  = W_DATA; p_ws = W_STRB;
        p_arv = AR_VALID; p_arr = AR_READY; p_ara = AR_ADDR;
    end

    task automatic step();
        @(negedge A_CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        REQ_WRITE[i]         = wr;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_WDATA[i*DW +: DW] = d;
        REQ_WSTRB[i*SW +: SW] = s;
    endtask

    task automatic wait_ack(input string tag, output int idx, output int acyc,
                            output logic [DW-1:0] rd, output logic [1:0] rs);
        idx = -1; acyc = 0; rd = '0; rs = '0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (REQ_ACK != '0) begin
                acyc = cyc;
                rd   = RSP_RDATA;
                rs   = RSP_RESP;
                for (int i = 0; i < N; i++) if (REQ_ACK[i]) idx = i;
                check({tag, "_onehot"}, 64'($onehot(REQ_ACK)), 1);
                step();
                check({tag, "_pulse"}, REQ_ACK, 0);
                return;
            end
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    int idx, ac, c0, seen;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    int cnt [N];
    int exp_st [4];

    initial begin
        A_RST = 1; REQ_VALID = 0; REQ_WRITE = 0;
        REQ_ADDR = 0; REQ_WDATA = 0; REQ_WSTRB = 0;
        repeat (3) step();
        check("rst_valids", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY}, 0);
        check("rst_ack", REQ_ACK, 0);
        check("rst_rdata", RSP_RDATA, 0);
        check("rst_resp", RSP_RESP, 0);
        A_RST = 0;
        step();

        // Single read from requester 1
        ar_dly = 3; r_dly = 0; rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
        set_req(1, 0, 32'h40, 0, 0);
        REQ_VALID = 4'b0010;
        c0 = cyc;
        step();
        check("rd_latency", AR_VALID, 1);
        check("rd_addr", AR_ADDR, 32'h40);
        wait_ack("rd", idx, ac, rd, rs);
        REQ_VALID = 0;
        check("rd_idx", idx, 1);
        check("rd_ar_wait", ar_hs_c - (c0 + 1), 3);
        check("rd_ack_lat", ac - r_hs_c, 1);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_resp", rs, 2'b00);

        // Write, W accepted before AW, SLVERR returned
        aw_dly = 3; w_dly = 0; b_dly = 2; bresp_cfg = 2'b10;
        set_req(0, 1, 32'h10, 32'h12345678, 4'hF);
        REQ_VALID = 4'b0001;
        step();
        check("wr_valids", {AW_VALID, W_VALID}, 2'b11);
        check("wr_addr", AW_ADDR, 32'h10);
        check("wr_data", W_DATA, 32'h12345678);
        check("wr_strb", W_STRB, 4'hF);
        step();
        check("wr_wdrop", {AW_VALID, W_VALID}, 2'b10);
        wait_ack("wr", idx, ac, rd, rs);
        REQ_VALID = 0;
        check("wr_idx", idx, 0);
        check("wr_order", 64'(w_hs_c < aw_hs_c), 1);
        check("wr_resp", rs, 2'b10);
        check("wr_rdata_kept", rd, 32'hDEADBEEF);

        // Backpressure: AW and W both held off for 20 cycles
        aw_dly = 20; w_dly = 20; b_dly = 0; bresp_cfg = 2'b00;
        set_req(3, 1, 32'h30, 32'hA5A50F0F, 4'h3);
        REQ_VALID = 4'b1000;
        c0 = cyc;
        repeat (10) step();
        check("bp_valids", {AW_VALID, W_VALID}, 2'b11);
        check("bp_addr", AW_ADDR, 32'h30);
        check("bp_data", W_DATA, 32'hA5A50F0F);
        check("bp_noack", REQ_ACK, 0);
        wait_ack("bp", idx, ac, rd, rs);
        REQ_VALID = 0;
        check("bp_idx", idx, 3);
        check("bp_aw_wait", aw_hs_c - c0, 21);
        check("bp_ack_cyc", ac - c0, 23);
        check("bp_resp", rs, 2'b00);

        // Round-robin with all four requesting continuously
        aw_dly = 0; w_dly = 0; ar_dly = 1; b_dly = 0; r_dly = 1;
        rdata_cfg = 32'hCAFE0001;
        set_req(0, 1, 32'h100, 32'h11, 4'hF);
        set_req(1, 0, 32'h104, 32'h22, 4'hF);
        set_req(2, 1, 32'h108, 32'h33, 4'hF);
        set_req(3, 0, 32'h10C, 32'h44, 4'hF);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        REQ_VALID = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ack($sformatf("rr%0d", k), idx, ac, rd, rs);
            check($sformatf("rr_order%0d", k), idx, k % 4);
            if (idx >= 0 && idx < N) cnt[idx]++;
        end
        REQ_VALID = 0;
        for (int i = 0; i < N; i++) check($sformatf("rr_count%0d", i), cnt[i], 2);

        // Starvation: 0 and 2 busy, 3 joins after the first grant
        A_RST = 1;
        repeat (2) step();
        A_RST = 0;
        exp_st[0] = 0; exp_st[1] = 2; exp_st[2] = 3; exp_st[3] = 0;
        REQ_VALID = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("st%0d", k), idx, ac, rd, rs);
            check($sformatf("st_order%0d", k), idx, exp_st[k]);
            if (k == 0) REQ_VALID[3] = 1'b1;
        end
        REQ_VALID = 0;

        // Reset during RD_DATA aborts without an ack
        r_dly = 30;
        set_req(1, 0, 32'h80, 0, 0);
        REQ_VALID = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            step();
            if (R_READY) break;
        end
        check("mid_rdphase", R_READY, 1);
        A_RST = 1;
        REQ_VALID = 0;
        step();
        check("mid_valids", {AW_VALID, W_VALID, B_READY, AR_VALID, R_READY}, 0);
        check("mid_ack", REQ_ACK, 0);
        check("mid_rdata", RSP_RDATA, 0);
        check("mid_resp", RSP_RESP, 0);
        step();
        A_RST = 0;
        seen = 0;
        repeat (5) begin
            step();
            if (REQ_ACK != 0) seen++;
        end
        check("mid_noack", seen, 0);
        r_dly = 0;
        set_req(0, 0, 32'h200, 0, 0);
        set_req(3, 0, 32'h20C, 0, 0);
        REQ_VALID = 4'b1001;
        wait_ack("post_rst", idx, ac, rd, rs);
        REQ_VALID = 0;
        check("post_rst_idx", idx, 0);

        check("stability", stab_err, 0);
        check("bready_early", bready_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
